// File: rtl/pixel_stream_scan.sv
// Raster-scan sequencer: walks ROW/COL over the image reader, applies a per-channel
// point operation and emits pixels on a valid/ready stream with SOF/EOL/EOF markers.
module pixel_stream_scan #(
  parameter int MAX_WIDTH  = 1080,
  parameter int MAX_HEIGHT = 1080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic [7:0]  i_value,
  input  logic [11:0] i_width,
  input  logic [11:0] i_height,
  output logic [11:0] o_row,
  output logic [11:0] o_col,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_busy,
  output logic        o_done
);

  // state   | meaning
  // S_IDLE  | waiting for START, ROW/COL parked at 0
  // S_FETCH | reader data for ROW/COL is captured and processed
  // S_EMIT  | pixel presented, held until accepted
  // S_DONE  | frame finished, DONE pulse follows, ROW/COL cleared
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  localparam logic [11:0] LP_MAX_W = 12'(MAX_WIDTH);
  localparam logic [11:0] LP_MAX_H = 12'(MAX_HEIGHT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_w, r_h, r_row, r_col;
  logic [1:0]  r_mode;
  logic [7:0]  r_value, r_r, r_g, r_b;
  logic        r_valid, r_sof, r_eol, r_eof, r_done;
  logic [11:0] w_w, w_h;
  logic        w_accept, w_last_col;

  assign w_w        = (i_width  > LP_MAX_W) ? LP_MAX_W : i_width;
  assign w_h        = (i_height > LP_MAX_H) ? LP_MAX_H : i_height;
  assign w_accept   = r_valid & i_ready;
  assign w_last_col = (r_col == r_w - 12'd1);

  // 9-bit intermediate keeps the carry/borrow for saturation.
  function automatic logic [7:0] f_op(input logic [1:0] m, input logic [7:0] v,
                                      input logic [7:0] x);
    logic [8:0] t;
    logic [7:0] y;
    t = 9'd0;
    y = x;
    case (m)
      2'd1: begin t = {1'b0, x} + {1'b0, v}; y = t[8] ? 8'hFF : t[7:0]; end
      2'd2: begin t = {1'b0, x} - {1'b0, v}; y = t[8] ? 8'h00 : t[7:0]; end
      2'd3: y = 8'hFF - x;
      default: y = x;
    endcase
    return y;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (w_w == 12'd0 || w_h == 12'd0) ? S_DONE : S_FETCH;
      S_FETCH: w_state_nxt = S_EMIT;
      S_EMIT:  if (w_accept) w_state_nxt = r_eof ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_w     <= '0;
      r_h     <= '0;
      r_mode  <= '0;
      r_value <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_w     <= w_w;
          r_h     <= w_h;
          r_mode  <= i_mode;
          r_value <= i_value;
          r_row   <= '0;
          r_col   <= '0;
        end
        S_FETCH: begin
          r_r     <= f_op(r_mode, r_value, i_red);
          r_g     <= f_op(r_mode, r_value, i_green);
          r_b     <= f_op(r_mode, r_value, i_blue);
          r_sof   <= (r_row == 12'd0) && (r_col == 12'd0);
          r_eol   <= w_last_col;
          r_eof   <= w_last_col && (r_row == r_h - 12'd1);
          r_valid <= 1'b1;
        end
        S_EMIT: if (w_accept) begin
          r_valid <= 1'b0;
          if (!r_eof) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 12'd1;
            end else begin
              r_col <= r_col + 12'd1;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_row  <= '0;
          r_col  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_valid = r_valid;
  assign o_r     = r_r;
  assign o_g     = r_g;
  assign o_b     = r_b;
  assign o_sof   = r_sof;
  assign o_eol   = r_eol;
  assign o_eof   = r_eof;
  assign o_busy  = (r_state == S_FETCH) || (r_state == S_EMIT);
  assign o_done  = r_done;

endmodule
